// File: rtl/router_pkg.sv
// router_pkg: constants and FSM state encoding shared by the 1x3 router
// blocks (router_fsm, router_fifo, router_sync).
//   NUM_PORTS          number of destination FIFOs (legal addresses 0..NUM_PORTS-1)
//   ADDR_W             width of the header address field (din[1:0])
//   ADDR_INVALID       the one unused address code; such headers are dropped
//   DEF_TIMEOUT_CYCLES default wait limit for the optional wait timeout
//   state_t            3-bit encoding of the eight packet-sequencing states
package router_pkg;

  localparam int NUM_PORTS          = 3;
  localparam int ADDR_W             = 2;
  localparam int DEF_TIMEOUT_CYCLES = 30;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: cycle counter for the WAIT_TILL_EMPTY timeout of
// router_fsm. Only instantiated when ROUTER_FSM_TIMEOUT_EN is defined.
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset (clears the count)
//   i_run      high for every cycle the FSM stays eligible to wait; low clears
//   o_expired  high in the cycle the count reaches TIMEOUT_CYCLES-1 while running
module router_wait_timer #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Count is 0 on the first WAIT cycle because every other state clears it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller of the 1x3 router. Decodes the
// header address, waits for the destination FIFO to drain, then sequences
// header, payload and parity loads; handles FIFO-full stalls and per-port
// soft reset.
// Optional feature: define ROUTER_FSM_TIMEOUT_EN to abandon WAIT_TILL_EMPTY
// after TIMEOUT_CYCLES cycles and pulse timeout_err.
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   pkt_valid              source packet-valid (header+payload)
//   data_in[1:0]           address field of the current input byte
//   fifo_full              full flag of the addressed FIFO
//   fifo_empty[2:0]        per-FIFO empty flags
//   sft_rst[2:0]           per-FIFO soft-reset pulses
//   parity_done            register block captured the parity byte
//   low_pkt_valid          pkt_valid fell while the FIFO was full
//   busy                   stall the source
//   detect_add, lfd_state, ld_state, laf_state, full_state  state strobes
//   write_enb_reg          register block writes to the FIFO
//   rst_int_reg            parity-check strobe
//   addr_q[1:0]            latched destination address
//   timeout_err            wait-timeout pulse (0 without the feature)
module router_fsm
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] sft_rst,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic [ADDR_W-1:0]    addr_q,
  output logic                 timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("router_fsm: TIMEOUT_CYCLES must be at least 2");
  end

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic              w_soft;
  logic              w_addr_ok;
  logic              w_timeout;

  // Soft reset only matters for the port currently being served.
  assign w_soft    = (r_state != DECODE_ADDRESS) && sft_rst[r_addr_q];
  assign w_addr_ok = pkt_valid && (data_in != ADDR_INVALID)
                     && (32'(data_in) < NUM_PORTS);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic w_expired;
  logic r_timeout_err;

  router_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rstn     (rstn),
    .i_run    ((r_state == WAIT_TILL_EMPTY) && !w_soft),
    .o_expired(w_expired)
  );

  // A FIFO that drains in the expiry cycle still wins over the timeout.
  assign w_timeout = w_expired && !fifo_empty[r_addr_q];

  // Registered so the pulse lines up with the first DECODE_ADDRESS cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register and address latch
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == DECODE_ADDRESS) && w_addr_ok) begin
        r_addr_q <= data_in;
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    if (w_soft) begin
      w_next = DECODE_ADDRESS;
    end else begin
      unique case (r_state)
        DECODE_ADDRESS: begin
          if (w_addr_ok) begin
            w_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: w_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       w_next = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) w_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        w_next = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next = LOAD_PARITY;
          else                    w_next = LOAD_DATA;
        end
        LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (fifo_empty[r_addr_q]) w_next = LOAD_FIRST_DATA;
          else if (w_timeout)       w_next = DECODE_ADDRESS;
        end
        default: w_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY)
                    || (r_state == LOAD_AFTER_FULL);
    busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  end

  assign addr_q = r_addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenarios followed by randomized traffic,
// every cycle compared against a packet-level reference model.
module tb_router_fsm;

  localparam int NP = 3;
  localparam int TC = 30;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, sft_rst;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, timeout_err;
  logic [1:0] addr_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk          (clk),
    .rstn         (rstn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .sft_rst      (sft_rst),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .busy         (busy),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .addr_q       (addr_q),
    .timeout_err  (timeout_err)
  );

  // Reference model: packet phase of the router as seen from outside.
  typedef enum int {P_IDLE, P_HEAD, P_BODY, P_PARITY, P_STALL, P_RESUME,
                    P_HOLD, P_CHECK} phase_t;
  phase_t m_ph;
  int     m_addr;
  int     m_wait;   // cycles already spent waiting for the FIFO to drain
  bit     m_terr;

  task automatic model_step();
    phase_t nph;
    bit     terr;
    terr = 1'b0;
    if (!rstn) begin
      m_ph = P_IDLE; m_addr = 0; m_wait = 0; m_terr = 1'b0;
      return;
    end
    nph = m_ph;
    if (m_ph != P_IDLE && sft_rst[m_addr]) begin
      nph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE:
          if (pkt_valid && int'(data_in) < NP) begin
            m_addr = int'(data_in);
            nph = fifo_empty[m_addr] ? P_HEAD : P_HOLD;
          end
        P_HEAD:   nph = P_BODY;
        P_BODY:   nph = fifo_full ? P_STALL : (pkt_valid ? P_BODY : P_PARITY);
        P_STALL:  nph = fifo_full ? P_STALL : P_RESUME;
        P_RESUME: nph = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
        P_PARITY: nph = P_CHECK;
        P_CHECK:  nph = fifo_full ? P_STALL : P_IDLE;
        P_HOLD:
          if (fifo_empty[m_addr]) nph = P_HEAD;
          else if (TO_ON && m_wait == TC - 1) begin
            nph = P_IDLE; terr = 1'b1;
          end
        default:  nph = P_IDLE;
      endcase
    end
    m_wait = (m_ph == P_HOLD && nph == P_HOLD) ? m_wait + 1 : 0;
    m_ph   = nph;
    m_terr = terr;
  endtask

  function automatic logic [10:0] model_outputs();
    logic dec, ld;
    dec = (m_ph == P_IDLE);
    ld  = (m_ph == P_BODY);
    return {!(dec || ld), dec, m_ph == P_HEAD, ld, m_ph == P_RESUME,
            m_ph == P_STALL, ld || m_ph == P_PARITY || m_ph == P_RESUME,
            m_ph == P_CHECK, 2'(m_addr), m_terr};
  endfunction

  logic [10:0] w_obs;
  assign w_obs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, addr_q, timeout_err};

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic cyc(input string tag);
    logic [10:0] exp_v;
    @(posedge clk);
    model_step();
    exp_v = model_outputs();
    #1;
    checks++;
    assert (w_obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (busy,det,lfd,ld,laf,full,wen,rst,addr,terr)",
             tag, w_obs, exp_v);
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; sft_rst = 3'b000; fifo_empty = 3'b111;
  endtask

  initial begin
    int n_lfd, n_ld, first_dec, terr_at;
    idle_inputs();
    rstn = 1'b0;

    // Reset
    cyc("reset0");
    cyc("reset1");
    chk("rst_detect_add", int'(detect_add), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr_q", int'(addr_q), 0);
    rstn = 1'b1;
    repeat (3) cyc("idle");
    chk("idle_detect_add", int'(detect_add), 1);

    // Header 8'h51: addr 1, 20 payload bytes, all FIFOs empty
    pkt_valid = 1'b1; data_in = 2'b01;
    cyc("hdr51");
    n_lfd = int'(lfd_state); n_ld = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = 2'($urandom);
      cyc("payload51");
      n_lfd += int'(lfd_state); n_ld += int'(ld_state);
    end
    chk("pkt51_lfd_cycles", n_lfd, 1);
    chk("pkt51_ld_cycles", n_ld, 20);
    pkt_valid = 1'b0;
    cyc("parity51");
    chk("parity51_wenb", int'(write_enb_reg), 1);
    cyc("check51");
    chk("check51_rst_int", int'(rst_int_reg), 1);
    cyc("done51");
    chk("done51_detect", int'(detect_add), 1);
    chk("done51_addr", int'(addr_q), 1);

    // Address 2 with its FIFO still occupied
    fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'b10;
    cyc("hdr2_wait");
    chk("wait2_busy", int'(busy), 1);
    repeat (4) cyc("wait2");
    fifo_empty = 3'b111;
    cyc("wait2_release");
    chk("wait2_lfd", int'(lfd_state), 1);
    repeat (3) cyc("payload2");
    pkt_valid = 1'b0;
    repeat (3) cyc("tail2");

    // FIFO full mid-payload, resumed via low_pkt_valid
    pkt_valid = 1'b1; data_in = 2'b00;
    repeat (3) cyc("hdr0_full");
    fifo_full = 1'b1;
    cyc("full0");
    chk("full0_state", int'(full_state), 1);
    chk("full0_busy", int'(busy), 1);
    repeat (3) cyc("full0_hold");
    fifo_full = 1'b0;
    cyc("laf0");
    chk("laf0_state", int'(laf_state), 1);
    pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    cyc("laf0_low");
    chk("laf0_to_parity", int'(write_enb_reg & busy & ~laf_state), 1);
    low_pkt_valid = 1'b0;
    repeat (2) cyc("tail0");

    // FIFO full, resumed with parity_done
    pkt_valid = 1'b1; data_in = 2'b00;
    repeat (2) cyc("hdr0b");
    fifo_full = 1'b1;
    cyc("full0b");
    fifo_full = 1'b0;
    cyc("laf0b");
    pkt_valid = 1'b0; parity_done = 1'b1;
    cyc("laf0b_done");
    chk("laf0b_to_decode", int'(detect_add), 1);
    parity_done = 1'b0;

    // Invalid address is dropped
    pkt_valid = 1'b1; data_in = 2'b11;
    repeat (3) cyc("hdr_invalid");
    chk("invalid_detect", int'(detect_add), 1);
    chk("invalid_addr_q", int'(addr_q), 0);
    pkt_valid = 1'b0;

    // Soft reset: other port ignored, own port aborts
    pkt_valid = 1'b1; data_in = 2'b01;
    repeat (2) cyc("hdr1_sft");
    sft_rst = 3'b001;
    cyc("sft_other");
    chk("sft_other_ld", int'(ld_state), 1);
    sft_rst = 3'b000;
    cyc("sft_mid");
    sft_rst = 3'b010;
    cyc("sft_own");
    chk("sft_own_detect", int'(detect_add), 1);
    sft_rst = 3'b000; pkt_valid = 1'b0;
    cyc("sft_after");

    // Long wait on port 0
    fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 2'b00;
    cyc("hdr0_long_wait");
    pkt_valid = 1'b0;
    first_dec = -1; terr_at = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc("long_wait");
      if (first_dec < 0 && detect_add === 1'b1) first_dec = k;
      if (terr_at < 0 && timeout_err === 1'b1) terr_at = k;
    end
    chk("wait_exit_cycle", first_dec, TO_ON ? TC : -1);
    chk("timeout_err_cycle", terr_at, TO_ON ? TC : -1);
    fifo_empty = 3'b111;
    repeat (5) cyc("long_wait_tail");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rstn          = ($urandom_range(0, 199) != 0);
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom);
      fifo_full     = ($urandom_range(0, 9) < 2);
      fifo_empty    = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0};
      sft_rst       = {$urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
                       $urandom_range(0, 31) == 0};
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 4) == 0);
      cyc("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-sequencing controller for the 1x3 router.
- Decodes the 2-bit destination address from the header byte and waits until the destination FIFO is free.
- Sequences header, payload and parity loading through the input register into the three router_fifo instances.
- Drives lfd_state to the FIFOs, busy back to the source, and parity-check and full-handling strobes to the register block.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; legal addresses are 0..NUM_PORTS-1.
- ADDR_W, 2, width of the header address field (din[1:0]).
- TIMEOUT_CYCLES, 30, wait limit in WAIT_TILL_EMPTY; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source asserts for the duration of header+payload; parity byte follows its deassertion.
- data_in  in  ADDR_W  address field of the current input byte (din[1:0]).
- fifo_full  in  1  full flag of the currently addressed FIFO (selected by the sync block).
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- sft_rst  in  NUM_PORTS  per-FIFO soft-reset (read timeout) pulses.
- parity_done  in  1  register block has captured the parity byte.
- low_pkt_valid  in  1  register block saw pkt_valid fall while the FIFO was full.
- busy  out  1  stall the source.
- detect_add  out  1  header decode cycle.
- lfd_state  out  1  load first data (header) into the FIFO.
- ld_state  out  1  payload load.
- laf_state  out  1  load after full.
- full_state  out  1  FIFO-full hold.
- write_enb_reg  out  1  register block writes to the FIFO.
- rst_int_reg  out  1  parity-check strobe.
- addr_q  out  ADDR_W  latched destination address.
- timeout_err  out  1  wait timeout pulse (optional feature).

Behaviour:
- State register: rstn=0 at posedge clk -> DECODE_ADDRESS, addr_q=0, timeout counter=0.
- Outputs are a Moore decode of state, so the reset values are detect_add=1 and all other outputs 0.
- Output decode:
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- DECODE_ADDRESS:
  - pkt_valid & data_in < NUM_PORTS: latch addr_q = data_in, then go to LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY.
  - data_in = 3 (invalid) or pkt_valid = 0: stay; the byte is dropped.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditional, 1 cycle.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE (has priority).
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: stay while fifo_full; -> LOAD_AFTER_FULL when it clears.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR, unconditional.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA, else stay.
- Soft reset: sft_rst[addr_q]=1 in any non-DECODE state -> DECODE_ADDRESS next cycle.
  - Overrides all other transitions.
  - sft_rst of other ports is ignored.
  - In DECODE_ADDRESS, sft_rst has no effect.
- Priority: rstn > sft_rst[addr_q] > normal transitions.
- addr_q changes only when leaving DECODE_ADDRESS.
- A header arriving in the same cycle the previous packet's CHECK_PARITY_ERROR exits is not decoded until the FSM is in DECODE_ADDRESS; the source must honour busy.
- Latency: header in DECODE_ADDRESS cycle -> lfd_state high the next cycle when the FIFO is empty.

Optional Feature:
- Macro: ROUTER_FSM_TIMEOUT_EN.
- With the macro:
  - An internal counter increments each cycle in WAIT_TILL_EMPTY and clears on entry and in every other state.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to DECODE_ADDRESS, and timeout_err pulses for 1 cycle on the cycle the FSM enters DECODE_ADDRESS.
  - Soft reset and rstn also clear the counter.
- Without the macro: no counter, timeout_err tied 0, and WAIT_TILL_EMPTY waits indefinitely.

Decomposition:
- Shared package router_pkg: state encodings (3-bit, 8 states), NUM_PORTS, ADDR_W, ADDR_INVALID=2'b11.
- router_fifo and router_sync reuse these constants.
- One sub-module is natural: router_wait_timer (counter + compare, instantiated only under ROUTER_FSM_TIMEOUT_EN).
- Next-state and output decode stay in router_fsm.

Test Plan:
- rstn=0 for 2 cycles -> detect_add=1, all other outputs 0, addr_q=0; after release the FSM stays in DECODE with pkt_valid=0.
- Header 8'h51 (len 20, addr 1), fifo_empty=3'b111, pkt_valid held 21 cycles:
  - lfd_state high 1 cycle, then ld_state 20 cycles.
  - pkt_valid low -> write_enb_reg in LOAD_PARITY, then rst_int_reg 1 cycle, then detect_add.
- addr 2 with fifo_empty[2]=0:
  - busy=1 in WAIT_TILL_EMPTY.
  - fifo_empty[2] rising -> lfd_state the next cycle.
- fifo_full=1 mid-payload:
  - full_state/busy high while fifo_full=1.
  - fifo_full=0 -> laf_state 1 cycle.
  - low_pkt_valid=1 -> LOAD_PARITY.
  - parity_done=1 -> DECODE.
- Header with data_in=2'b11 and pkt_valid=1 -> stays in DECODE, addr_q unchanged.
- sft_rst[1]=1 during LOAD_DATA with addr_q=1 -> detect_add the next cycle; sft_rst[0] pulse at the same point -> no effect.
- ROUTER_FSM_TIMEOUT_EN, TIMEOUT_CYCLES=30: fifo_empty[0] held 0 -> timeout_err 1-cycle pulse on the cycle detect_add reasserts, 30 cycles after WAIT entry.
